// File: rtl/io_trace_defs.sv
// Shared definitions for the I/O trace capture block: default geometry and
// the layout of one trace entry {channel, value, timestamp}, MSB first.
package io_trace_defs;

   localparam int DEF_NCH   = 4;
   localparam int DEF_W     = 8;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_TSW   = 32;
   localparam int DEF_CW    = $clog2(DEF_NCH);
   localparam int ENTRY_W   = DEF_CW + DEF_W + DEF_TSW;

   function automatic int entry_width(input int cw, input int w, input int tsw);
      return cw + w + tsw;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO holding trace entries; head is valid whenever not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo
   import io_trace_defs::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int EW    = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [EW-1:0]            push_data,
   input  logic                     pop,
   output logic [EW-1:0]            head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign head  = mem[rd_ptr];

   // Storage carries no reset; the head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_trace_capture.sv
// Records every value change on NCH monitored output channels as
// {channel, value, timestamp} entries, drained through a ready/valid port.
module io_trace_capture
   import io_trace_defs::*;
#(
   parameter int NCH   = DEF_NCH,
   parameter int W     = DEF_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int TSW   = DEF_TSW,
   parameter int CW    = $clog2(NCH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NCH*W-1:0]         ch_in,
   input  logic [NCH-1:0]           ch_mask,
   input  logic                     clr_ovf,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [CW-1:0]            rd_ch,
   output logic [W-1:0]             rd_data,
   output logic [TSW-1:0]           rd_time,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int EW = entry_width(CW, W, TSW);

   logic [TSW-1:0] ts;
   logic [W-1:0]   prev      [NCH];
   logic [W-1:0]   pend_data [NCH];
   logic [TSW-1:0] pend_time [NCH];
   logic [NCH-1:0] pending;
   logic [NCH-1:0] evt;
   logic [NCH-1:0] gnt_vec;
   logic [CW-1:0]  last_grant;
   logic [CW-1:0]  gnt_idx;
   logic           gnt_any;
   logic           do_grant;
   logic           ovf_set;
   logic           pop;
   logic           full;
   logic           empty;
   logic [EW-1:0]  push_entry;
   logic [EW-1:0]  head;

   always_comb begin
      evt = '0;
      for (int c = 0; c < NCH; c++) begin
         evt[c] = en && ch_mask[c] && (ch_in[c*W +: W] != prev[c]);
      end
   end

   // Round-robin: search starts just after the channel granted last.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 1; i <= NCH; i++) begin
         if (!gnt_any && pending[(int'(last_grant) + i) % NCH]) begin
            gnt_any = 1'b1;
            gnt_idx = CW'((int'(last_grant) + i) % NCH);
         end
      end
   end

   assign pop      = rd_valid && rd_ready;
   assign do_grant = gnt_any && (!full || pop);

   // A fresh event on the channel being pushed this cycle is not a loss.
   always_comb begin
      gnt_vec = '0;
      ovf_set = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         gnt_vec[c] = do_grant && (gnt_idx == CW'(c));
         if (evt[c] && pending[c] && !gnt_vec[c]) begin
            ovf_set = 1'b1;
         end
      end
   end

   assign push_entry = {gnt_idx, pend_data[gnt_idx], pend_time[gnt_idx]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts         <= '0;
         pending    <= '0;
         last_grant <= CW'(NCH - 1);
         overflow   <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            prev[c]      <= '0;
            pend_data[c] <= '0;
            pend_time[c] <= '0;
         end
      end else begin
         ts <= ts + 1'b1;
         if (do_grant) begin
            last_grant <= gnt_idx;
         end
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
         for (int c = 0; c < NCH; c++) begin
            prev[c] <= ch_in[c*W +: W];
            if (evt[c]) begin
               pending[c]   <= 1'b1;
               pend_data[c] <= ch_in[c*W +: W];
               pend_time[c] <= ts;
            end else if (gnt_vec[c]) begin
               pending[c] <= 1'b0;
            end
         end
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .EW    (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (do_grant),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign rd_valid = !empty;
   assign rd_ch    = rd_valid ? head[EW-1 -: CW] : '0;
   assign rd_data  = rd_valid ? head[TSW +: W]   : '0;
   assign rd_time  = rd_valid ? head[TSW-1:0]    : '0;

endmodule

// File: doc/io_trace_capture.md
# io_trace_capture

Parametrised, synthesizable successor to the SoC simulation monitor. It watches NCH memory-mapped output channels (LEDs, UART data, UART control, …) and records every value change as an entry {channel, new value, cycle timestamp} in an on-chip FIFO. A consumer (debug UART or bench) drains the FIFO through a ready/valid port. It sits beside `top`, tapping peripheral output registers, with no effect on CPU timing.

## Interface
- NCH, 4: number of monitored channels (≥2)
- W, 8: width of each channel value
- DEPTH, 16: FIFO entries (power of 2, ≥2)
- TSW, 32: timestamp counter width
- CW, $clog2(NCH): channel index width (derived)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  capture enable
- ch_in  in  NCH*W  channel values; channel c occupies bits [c*W +: W]
- ch_mask  in  NCH  per-channel capture enable
- clr_ovf  in  1  clears `overflow`
- rd_valid  out  1  FIFO head entry is valid
- rd_ready  in  1  consumer accepts head entry
- rd_ch  out  CW  head entry channel index
- rd_data  out  W  head entry value
- rd_time  out  TSW  head entry timestamp
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: an event was lost

## Operation
- Reset (async, rst=0): timestamp, prev[], pending[], FIFO pointers, count, overflow, and round-robin pointer cleared; last-grant = NCH-1. All outputs 0.
- Timestamp `ts` increments every cycle from 0 and wraps modulo 2^TSW.
- prev[c] <= ch_in[c] every cycle, regardless of en/mask. Stale changes are not recorded when capture is re-enabled.
- Change event on channel c at an edge: en && ch_mask[c] && ch_in[c] != prev[c]. Sets pending[c] and captures pend_data[c]=ch_in[c], pend_time[c]=ts (pre-increment value).
- Event on a channel whose pending flag is set and not granted this cycle: overwrite data/time with the newest event and set overflow.
- Event on a channel granted this same cycle: pending stays set with the new data. Not an overflow.
- Arbiter: one grant per cycle, when any pending and FIFO can accept (count<DEPTH, or a pop occurs this cycle). Round-robin search starts at last-grant+1 (mod NCH). The granted entry is pushed and its pending flag is cleared.
- FIFO: show-ahead. rd_* reflect the head whenever rd_valid=1. Pop on rd_valid && rd_ready. Push+pop in the same cycle leaves count unchanged, and is allowed when full.
- rd_* hold their value while rd_valid && !rd_ready. rd_* are don't-care when rd_valid=0; the implementation drives 0.
- overflow: set has priority over clr_ovf in the same cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Timing
- Input change sampled at edge N. pending set at N. Pushed at N+1 at the earliest. rd_valid=1 after edge N+1, a latency of 2 cycles.
- k simultaneous events drain over k consecutive cycles when the FIFO has space. The timestamps are all equal to N.
- Throughput is 1 entry/cycle in and 1 entry/cycle out.
- No combinational path from rd_ready to rd_valid or rd_*. rd_ready only gates the pop.
- rst assertion mid-operation drops all queued and pending entries immediately. The first cycle after release has ts=0.

## Structure
- Shared package/header `io_trace_defs`: entry record layout {ch[CW], data[W], time[TSW]}, entry width constant ENTRY_W = CW+W+TSW, and the default parameter values.
- Sub-module `trace_fifo`: synchronous DEPTH×ENTRY_W show-ahead FIFO with push/pop/count/full/empty.
- The top level holds change detect, pending registers, the round-robin arbiter, and the timestamp counter.

## Test plan
- Reset/idle: rst=0 for 5 cycles then release, with ch_in held at 0 and en=1 for 20 cycles. Required: rd_valid=0, count=0, overflow=0 throughout.
- Single event: ch1 changes 0x00→0x5A at ts=10, rd_ready=1. Required: rd_valid high from ts=12, carrying a single entry {1, 0x5A, 10}, then rd_valid drops.
- Simultaneous events: right after reset, ch0, ch2 and ch3 change at ts=20. Required: three entries in order ch0, ch2, ch3 on consecutive cycles, all with time=20.
- Backpressure/overflow: rd_ready=0, 16 single-channel events fill the FIFO (count=16). A 17th event is held pending. An 18th event on the same channel (value 0xEE) sets overflow=1. Draining yields 16 entries, then {ch, 0xEE, ts of the 18th event}. A clr_ovf pulse then clears overflow.
- Mask/enable, with TSW=8: ch_mask=4'b1011 and ch2 toggles → no entry. en=0 while ch0 changes, then en=1 → no entry. A ch0 change at ts=255 then another at ts=0 → entries with time 255 then 0.
- Reset mid-stream: 5 entries queued plus 2 pending, then rst pulses low. Required: rd_valid=0, count=0 and overflow=0 asynchronously. After release, no stale entries appear.
